// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and constants for the pipeline sequencing controller.
// Imported by pipe_ctrl and hazard_detect.
package pipe_ctrl_pkg;

  localparam logic [1:0] PC_RUN      = 2'd0;
  localparam logic [1:0] PC_MEM_WAIT = 2'd1;
  localparam logic [1:0] PC_RELEASE  = 2'd2;
  localparam logic [1:0] PC_DRAIN    = 2'd3;

  localparam logic [4:0]  ZERO_REG  = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
// x0 is never a real dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_load_i,
  input  logic [4:0] ex_rd_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  output logic       stall_o
);

  assign stall_o = ex_load_i
                && (ex_rd_i != ZERO_REG)
                && ((ex_rd_i == id_rs1_i)
                 || (ex_rd_i == id_rs2_i));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: jump/load/load-use arbitration and the
// data-memory read port. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [31:0] RESET_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_mem_rd_req_i,
  input  logic [31:0] id_mem_rd_addr_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_jump_en_i,
  input  logic [31:0] ex_jump_addr_i,
  output logic        mem_rd_req_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic        mem_rd_valid_i,
  input  logic [31:0] mem_rd_data_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        mem_err_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] jaddr_q, jaddr_d;
  logic        lu_q, lu_d;
  logic        lu_stall;
  logic        tmo;
  logic        hold;
  logic        jump;

  hazard_detect u_hazard (
    .ex_load_i (ex_load_i),
    .ex_rd_i   (ex_rd_addr_i),
    .id_rs1_i  (id_rs1_addr_i),
    .id_rs2_i  (id_rs2_addr_i),
    .stall_o   (lu_stall)
  );

  assign tmo = (timer_q == TMO_LAST);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    req_d    = req_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    lu_d     = 1'b0;
    hold     = 1'b0;
    jump     = 1'b0;
    unique case (state_q)
      PC_RUN: begin
        if (ex_jump_en_i) begin
          jump = 1'b1;
        end else if (id_mem_rd_req_i) begin
          hold    = 1'b1;
          req_d   = 1'b1;
          addr_d  = id_mem_rd_addr_i;
          timer_d = 8'd0;
          state_d = PC_MEM_WAIT;
        end else if (lu_stall && !lu_q) begin
          // lu_q keeps a held hazard to a single bubble
          hold = 1'b1;
          lu_d = 1'b1;
        end
      end
      PC_MEM_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (ex_jump_en_i) begin
          jump = 1'b1;
          if (mem_rd_valid_i || tmo) begin
            req_d   = 1'b0;
            timer_d = 8'd0;
            state_d = PC_RUN;
          end else begin
            state_d = PC_DRAIN;
          end
        end else begin
          hold = 1'b1;
          if (mem_rd_valid_i) begin
            rdata_d  = mem_rd_data_i;
            rvalid_d = 1'b1;
            req_d    = 1'b0;
            timer_d  = 8'd0;
            state_d  = PC_RELEASE;
          end else if (tmo) begin
            rdata_d  = ZERO_WORD;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            req_d    = 1'b0;
            timer_d  = 8'd0;
            state_d  = PC_RELEASE;
          end
        end
      end
      PC_RELEASE: begin
        jump    = ex_jump_en_i;
        state_d = PC_RUN;
      end
      PC_DRAIN: begin
        timer_d = timer_q + 8'd1;
        jump    = ex_jump_en_i;
        hold    = !ex_jump_en_i;
        if (mem_rd_valid_i || tmo) begin
          req_d   = 1'b0;
          timer_d = 8'd0;
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_RUN;
    endcase
    jaddr_d = jump ? ex_jump_addr_i : jaddr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PC_RUN;
      timer_q  <= 8'd0;
      req_q    <= 1'b0;
      addr_q   <= RESET_ADDR;
      rdata_q  <= ZERO_WORD;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      jaddr_q  <= RESET_ADDR;
      lu_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      jaddr_q  <= jaddr_d;
      lu_q     <= lu_d;
    end
  end

  assign mem_rd_req_o  = req_q;
  assign mem_rd_addr_o = addr_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign mem_err_o     = err_q;
  assign hold_pc_o     = hold;
  assign hold_if_id_o  = hold;
  assign flush_if_id_o = jump;
  assign flush_id_ex_o = hold | jump;
  assign jump_en_o     = jump;
  assign jump_addr_o   = jump ? ex_jump_addr_i : jaddr_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_q + {31'd0, hold};
      flush_cnt_q <= flush_cnt_q + {31'd0, jump};
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: load-use, load latency, timeout, jumps, reset.
// Load results are scoreboarded and matched on each rdata_valid_o pulse.
module tb_pipe_ctrl;

  localparam logic [31:0] RA = 32'h0000_0200;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_req, ex_load, ex_jump;
  logic [31:0] id_addr, ex_jaddr;
  logic        mem_req, mem_valid;
  logic [31:0] mem_addr, mem_data;
  logic [31:0] rdata, jaddr;
  logic        rvalid, err;
  logic        hold_pc, hold_ifid, fl_ifid, fl_idex, jen;

  int checks = 0;
  int errors = 0;
  rd_exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl #(.MEM_TIMEOUT(4), .RESET_ADDR(RA)) dut (
    .clk              (clk),
    .rst              (rst),
    .id_rs1_addr_i    (id_rs1),
    .id_rs2_addr_i    (id_rs2),
    .id_mem_rd_req_i  (id_req),
    .id_mem_rd_addr_i (id_addr),
    .ex_load_i        (ex_load),
    .ex_rd_addr_i     (ex_rd),
    .ex_jump_en_i     (ex_jump),
    .ex_jump_addr_i   (ex_jaddr),
    .mem_rd_req_o     (mem_req),
    .mem_rd_addr_o    (mem_addr),
    .mem_rd_valid_i   (mem_valid),
    .mem_rd_data_i    (mem_data),
    .rdata_o          (rdata),
    .rdata_valid_o    (rvalid),
    .mem_err_o        (err),
    .hold_pc_o        (hold_pc),
    .hold_if_id_o     (hold_ifid),
    .flush_if_id_o    (fl_ifid),
    .flush_id_ex_o    (fl_idex),
    .jump_en_o        (jen),
    .jump_addr_o      (jaddr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (sb.size() == 0) begin
        chk("unexp_rvalid", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", rdata, e.data);
        chk("sb_err", {31'd0, err}, {31'd0, e.err});
      end
    end
    if (!rst && err && !rvalid)
      chk("err_wo_valid", 32'd1, 32'd0);
  end

  initial begin
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_req = 1'b0; ex_load = 1'b0; ex_jump = 1'b0;
    id_addr = '0; ex_jaddr = '0;
    mem_valid = 1'b0; mem_data = '0;
    tick; tick;
    smp;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, RA);
    chk("rst_jaddr", jaddr, RA);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {26'd0, rvalid, err, hold_pc, hold_ifid,
                      fl_ifid, fl_idex}, 32'd0);
    tick;
    rst = 1'b0;

    // load-use, held for two cycles: only one stall
    ex_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    smp;
    chk("lu_hold", {29'd0, hold_pc, hold_ifid, fl_idex}, 32'd7);
    chk("lu_nofl", {31'd0, fl_ifid}, 32'd0);
    tick;
    smp;
    chk("lu_once", {29'd0, hold_pc, hold_ifid, fl_idex}, 32'd0);
    tick;
    ex_rd = 5'd0; id_rs1 = 5'd0;
    smp;
    chk("lu_x0", {31'd0, hold_pc}, 32'd0);
    tick;
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    smp;
    chk("lu_rs2", {31'd0, hold_pc}, 32'd1);
    tick;
    ex_load = 1'b0; ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
    tick;

    // load with 3-cycle latency, id request held to probe reissue
    id_req = 1'b1; id_addr = 32'h100;
    sb.push_back('{data: 32'hDEAD_BEEF, err: 1'b0});
    smp;
    chk("ld_hold0", {30'd0, hold_pc, fl_idex}, 32'd3);
    chk("ld_req0", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      if (i == 2) begin
        mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF;
      end
      smp;
      chk("ld_req", {31'd0, mem_req}, 32'd1);
      chk("ld_addr", mem_addr, 32'h100);
      chk("ld_hold", {31'd0, hold_ifid}, 32'd1);
    end
    tick;
    mem_valid = 1'b0; mem_data = '0;
    smp;
    chk("rel_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rel_nohold", {31'd0, hold_pc}, 32'd0);
    chk("rel_req", {31'd0, mem_req}, 32'd0);
    tick;
    id_req = 1'b0;
    smp;
    chk("no_reissue", {31'd0, mem_req}, 32'd0);
    chk("rv_pulse", {31'd0, rvalid}, 32'd0);
    tick;

    // timeout after 4 wait cycles
    id_req = 1'b1; id_addr = 32'h300;
    sb.push_back('{data: 32'h0, err: 1'b1});
    tick;
    id_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp;
      chk("to_wait", {30'd0, mem_req, err}, 32'd2);
      chk("to_addr", mem_addr, 32'h300);
      tick;
    end
    smp;
    chk("to_err", {30'd0, err, rvalid}, 32'd3);
    chk("to_rdata", rdata, 32'd0);
    chk("to_req", {31'd0, mem_req}, 32'd0);
    tick;
    smp;
    chk("to_run", {30'd0, hold_pc, err}, 32'd0);
    tick;

    // valid on the timeout cycle: valid wins
    id_req = 1'b1; id_addr = 32'h340;
    sb.push_back('{data: 32'h0000_CAFE, err: 1'b0});
    tick;
    id_req = 1'b0;
    tick; tick; tick;
    mem_valid = 1'b1; mem_data = 32'h0000_CAFE;
    tick;
    mem_valid = 1'b0;
    smp;
    chk("vt_err", {31'd0, err}, 32'd0);
    tick; tick;

    // jump and load in the same cycle
    ex_jump = 1'b1; ex_jaddr = 32'h40; id_req = 1'b1; id_addr = 32'h400;
    smp;
    chk("jl_jen", {31'd0, jen}, 32'd1);
    chk("jl_addr", jaddr, 32'h40);
    chk("jl_flush", {29'd0, fl_ifid, fl_idex, hold_pc}, 32'd6);
    tick;
    ex_jump = 1'b0; id_req = 1'b0;
    smp;
    chk("jl_noreq", {31'd0, mem_req}, 32'd0);
    chk("jl_keep", jaddr, 32'h40);
    tick;

    // jump during MEM_WAIT: response drained and discarded
    id_req = 1'b1; id_addr = 32'h500;
    tick;
    id_req = 1'b0;
    tick;
    ex_jump = 1'b1; ex_jaddr = 32'h80;
    smp;
    chk("jw_jen", {30'd0, jen, fl_ifid}, 32'd3);
    chk("jw_addr", jaddr, 32'h80);
    tick;
    ex_jump = 1'b0;
    smp;
    chk("dr_req", {31'd0, mem_req}, 32'd1);
    tick;
    mem_valid = 1'b1; mem_data = 32'h1234;
    tick;
    mem_valid = 1'b0;
    smp;
    chk("dr_done", {30'd0, mem_req, rvalid}, 32'd0);
    chk("dr_rdata", rdata, 32'h0000_CAFE);
    chk("dr_run", {31'd0, hold_pc}, 32'd0);
    tick;

    // reset mid-transaction, then a stray response
    id_req = 1'b1; id_addr = 32'h600;
    tick;
    id_req = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; mem_valid = 1'b1; mem_data = 32'h9999;
    smp;
    chk("mr_req", {31'd0, mem_req}, 32'd0);
    chk("mr_addr", mem_addr, RA);
    chk("mr_jaddr", jaddr, RA);
    chk("mr_rdata", rdata, 32'd0);
    chk("mr_hold", {31'd0, hold_pc}, 32'd0);
    tick;
    mem_valid = 1'b0;
    smp;
    chk("mr_stray", {31'd0, rvalid}, 32'd0);
    chk("mr_rdata2", rdata, 32'd0);
    tick;

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
